// File: rtl/data_mem_hs.sv
// Byte-addressed little-endian data memory with req/ready/done handshake.
// Latency WAIT_CYCLES+1 edges; ready drops while wait states run, req is not queued while ready=0.
module data_mem_hs #(
    parameter int DEPTH       = 256,
    parameter int AW          = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req,
    input  logic          i_we,
    input  logic [1:0]    i_size,
    input  logic          i_sext,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic          o_ready,
    output logic          o_done,
    output logic [31:0]   o_rdata,
    output logic          o_err
);

    localparam int LW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_sext;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [7:0]    r_mem [DEPTH];

    logic          w_accept;
    logic          w_fire;
    logic          w_we;
    logic [1:0]    w_size;
    logic          w_sext;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_wdata;
    logic [LW-1:0] w_a0;
    logic [LW-1:0] w_a1;
    logic [LW-1:0] w_a2;
    logic [LW-1:0] w_a3;
    logic          w_err;
    logic          w_wr;
    logic [31:0]   w_load;

    assign w_accept = i_req && (r_state != S_WAIT);

    // Without wait states the access happens on the accepting edge, so operands come straight from the ports.
    assign w_fire  = (WAIT_CYCLES == 0) ? w_accept : ((r_state == S_WAIT) && (r_cnt == 4'd0));
    assign w_we    = (WAIT_CYCLES == 0) ? i_we    : r_we;
    assign w_size  = (WAIT_CYCLES == 0) ? i_size  : r_size;
    assign w_sext  = (WAIT_CYCLES == 0) ? i_sext  : r_sext;
    assign w_addr  = (WAIT_CYCLES == 0) ? i_addr  : r_addr;
    assign w_wdata = (WAIT_CYCLES == 0) ? i_wdata : r_wdata;

    assign w_a0 = w_addr[LW-1:0];
    assign w_a1 = w_a0 + LW'(1);
    assign w_a2 = w_a0 + LW'(2);
    assign w_a3 = w_a0 + LW'(3);

    always_comb begin
        w_err = 1'b0;
        if ((w_addr >> LW) != '0)                           w_err = 1'b1;
        if (w_size == 2'b11)                                w_err = 1'b1;
        if ((w_size == 2'b01) && w_addr[0])                 w_err = 1'b1;
        if ((w_size == 2'b10) && (w_addr[1:0] != 2'b00))    w_err = 1'b1;
    end

    assign w_wr = w_fire && w_we && !w_err && !i_rst;

    always_comb begin
        w_load = 32'h0;
        case (w_size)
            2'b00:   w_load = {{24{w_sext & r_mem[w_a0][7]}}, r_mem[w_a0]};
            2'b01:   w_load = {{16{w_sext & r_mem[w_a1][7]}}, r_mem[w_a1], r_mem[w_a0]};
            default: w_load = {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[w_a0]};
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[w_a0] <= w_wdata[7:0];
            if (w_size != 2'b00) r_mem[w_a1] <= w_wdata[15:8];
            if (w_size == 2'b10) begin
                r_mem[w_a2] <= w_wdata[23:16];
                r_mem[w_a3] <= w_wdata[31:24];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            o_ready <= 1'b1;
            o_done  <= 1'b0;
            o_rdata <= 32'h0;
            o_err   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (i_req) begin
                        r_we    <= i_we;
                        r_size  <= i_size;
                        r_sext  <= i_sext;
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_RESP;
                            o_ready <= 1'b1;
                            o_done  <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(WAIT_CYCLES - 1);
                            o_ready <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        o_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        o_ready <= 1'b1;
                        o_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_ready <= 1'b1;
                end
            endcase
            // Stores leave rdata untouched unless they fault.
            if (w_fire) begin
                o_err <= w_err;
                if (w_err)      o_rdata <= 32'h0;
                else if (!w_we) o_rdata <= w_load;
            end
        end
    end

endmodule
